// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Three-master round-robin arbiter in front of a single SDRAM controller.
//   Each master posts one transaction at a time (read, 16-beat burst read or
//   write) and holds mN_req until mN_ack. The winner's payload is registered
//   at arbitration and presented to the controller until it is accepted. A
//   small FIFO remembers which master owns each accepted read so that the
//   controller's sdram_complete pulse can be routed back to the right master.
//
// Ports
//   clock, reset                  system clock, synchronous active-high reset
//   mN_req/address/write/burst    master N request and command (N = 0..2)
//   mN_wstrb/wdata                master N write byte enables / write data
//   mN_ack                        master N transaction accepted this cycle
//   mN_rvalid/mN_complete         read beat valid / read finished for master N
//   m_rdata/m_raddress            read data/address broadcast to all masters
//   sdram_request                 one-hot granted master (000 = none)
//   sdram_ready                   controller accepts the presented request
//   sdram_address..sdram_wdata    registered payload of the granted master
//   sdram_rdata/raddress/rvalid   read return path from the controller
//   sdram_complete                a read or burst read has finished
module sdram_arbiter #(
    parameter int RDQ_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [25:0] m0_address,
    input  logic        m0_write,
    input  logic        m0_burst,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_rvalid,
    output logic        m0_complete,
    input  logic        m1_req,
    input  logic [25:0] m1_address,
    input  logic        m1_write,
    input  logic        m1_burst,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_rvalid,
    output logic        m1_complete,
    input  logic        m2_req,
    input  logic [25:0] m2_address,
    input  logic        m2_write,
    input  logic        m2_burst,
    input  logic [3:0]  m2_wstrb,
    input  logic [31:0] m2_wdata,
    output logic        m2_ack,
    output logic        m2_rvalid,
    output logic        m2_complete,
    output logic [31:0] m_rdata,
    output logic [25:0] m_raddress,
    output logic [2:0]  sdram_request,
    input  logic        sdram_ready,
    output logic [25:0] sdram_address,
    output logic        sdram_write,
    output logic        sdram_burst,
    output logic [3:0]  sdram_wstrb,
    output logic [31:0] sdram_wdata,
    input  logic [31:0] sdram_rdata,
    input  logic [25:0] sdram_raddress,
    input  logic [2:0]  sdram_rvalid,
    input  logic        sdram_complete
);

    localparam int PTR_W = $clog2(RDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        request_q, request_d;
    logic [25:0]       address_q, address_d;
    logic              write_q, write_d;
    logic              burst_q, burst_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [1:0]        mem_q [RDQ_DEPTH];
    logic [1:0]        mem_d [RDQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              fifo_full;
    logic [3:0]        eligible;
    logic              found;
    logic [1:0]        winner;
    logic [2:0]        cand;
    logic [1:0]        grant_idx;
    logic              accept;
    logic              push;
    logic              pop;
    logic [1:0]        head;

    assign fifo_full = (count_q == CNT_W'(RDQ_DEPTH));
    // Slot 3 never exists; keeping it zero lets the search index with 2 bits.
    assign eligible  = {1'b0,
                        m2_req & (m2_write | ~fifo_full),
                        m1_req & (m1_write | ~fifo_full),
                        m0_req & (m0_write | ~fifo_full)};

    // Round-robin search starting at rr_ptr, ascending modulo 3.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        cand   = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, rr_ptr_q} + 3'(i);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!found && eligible[cand[1:0]]) begin
                found  = 1'b1;
                winner = cand[1:0];
            end
        end
    end

    assign grant_idx = request_q[2] ? 2'd2 : (request_q[1] ? 2'd1 : 2'd0);
    assign accept    = (state_q == GRANT) && sdram_ready;
    assign push      = accept && !write_q;
    // A completion with nothing outstanding is dropped.
    assign pop       = sdram_complete && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        request_d = request_q;
        address_d = address_q;
        write_d   = write_q;
        burst_d   = burst_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = GRANT;
                    request_d = 3'b001 << winner;
                    case (winner)
                        2'd1: begin
                            address_d = m1_address;
                            write_d   = m1_write;
                            burst_d   = m1_burst;
                            wstrb_d   = m1_wstrb;
                            wdata_d   = m1_wdata;
                        end
                        2'd2: begin
                            address_d = m2_address;
                            write_d   = m2_write;
                            burst_d   = m2_burst;
                            wstrb_d   = m2_wstrb;
                            wdata_d   = m2_wdata;
                        end
                        default: begin
                            address_d = m0_address;
                            write_d   = m0_write;
                            burst_d   = m0_burst;
                            wstrb_d   = m0_wstrb;
                            wdata_d   = m0_wdata;
                        end
                    endcase
                end
            end
            GRANT: begin
                // Returning to IDLE leaves one bubble cycle between grants.
                if (sdram_ready) begin
                    state_d   = IDLE;
                    request_d = 3'b000;
                    rr_ptr_d  = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-owner FIFO; push and pop in one cycle leave the count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = grant_idx;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 2'd0;
            request_q <= 3'b000;
            address_q <= '0;
            write_q   <= 1'b0;
            burst_q   <= 1'b0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            request_q <= request_d;
            address_q <= address_d;
            write_q   <= write_d;
            burst_q   <= burst_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Owner entries are qualified by count, so they need no reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Acks and completions are suppressed while reset is held so nothing is
    // reported for a transaction that reset is throwing away.
    assign m0_ack      = request_q[0] & accept & ~reset;
    assign m1_ack      = request_q[1] & accept & ~reset;
    assign m2_ack      = request_q[2] & accept & ~reset;
    assign m0_complete = pop & ~reset & (head == 2'd0);
    assign m1_complete = pop & ~reset & (head == 2'd1);
    assign m2_complete = pop & ~reset & (head == 2'd2);

    assign m0_rvalid  = sdram_rvalid[0];
    assign m1_rvalid  = sdram_rvalid[1];
    assign m2_rvalid  = sdram_rvalid[2];
    assign m_rdata    = sdram_rdata;
    assign m_raddress = sdram_raddress;

    assign sdram_request = request_q;
    assign sdram_address = address_q;
    assign sdram_write   = write_q;
    assign sdram_burst   = burst_q;
    assign sdram_wstrb   = wstrb_q;
    assign sdram_wdata   = wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter: reset state, round-robin order, grant
//   hold under back-pressure, burst return routing, full read-owner queue,
//   simultaneous push/pop and reset during a grant.
module tb_sdram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m2_req;
    logic [25:0] m0_address, m1_address, m2_address;
    logic        m0_write, m1_write, m2_write;
    logic        m0_burst, m1_burst, m2_burst;
    logic [3:0]  m0_wstrb, m1_wstrb, m2_wstrb;
    logic [31:0] m0_wdata, m1_wdata, m2_wdata;
    logic        m0_ack, m1_ack, m2_ack;
    logic        m0_rvalid, m1_rvalid, m2_rvalid;
    logic        m0_complete, m1_complete, m2_complete;
    logic [31:0] m_rdata;
    logic [25:0] m_raddress;
    logic [2:0]  sdram_request;
    logic        sdram_ready;
    logic [25:0] sdram_address;
    logic        sdram_write, sdram_burst;
    logic [3:0]  sdram_wstrb;
    logic [31:0] sdram_wdata;
    logic [31:0] sdram_rdata;
    logic [25:0] sdram_raddress;
    logic [2:0]  sdram_rvalid;
    logic        sdram_complete;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sdram_arbiter #(.RDQ_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_address(m0_address), .m0_write(m0_write), .m0_burst(m0_burst),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rvalid(m0_rvalid),
        .m0_complete(m0_complete),
        .m1_req(m1_req), .m1_address(m1_address), .m1_write(m1_write), .m1_burst(m1_burst),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rvalid(m1_rvalid),
        .m1_complete(m1_complete),
        .m2_req(m2_req), .m2_address(m2_address), .m2_write(m2_write), .m2_burst(m2_burst),
        .m2_wstrb(m2_wstrb), .m2_wdata(m2_wdata), .m2_ack(m2_ack), .m2_rvalid(m2_rvalid),
        .m2_complete(m2_complete),
        .m_rdata(m_rdata), .m_raddress(m_raddress),
        .sdram_request(sdram_request), .sdram_ready(sdram_ready),
        .sdram_address(sdram_address), .sdram_write(sdram_write), .sdram_burst(sdram_burst),
        .sdram_wstrb(sdram_wstrb), .sdram_wdata(sdram_wdata),
        .sdram_rdata(sdram_rdata), .sdram_raddress(sdram_raddress),
        .sdram_rvalid(sdram_rvalid), .sdram_complete(sdram_complete)
    );

    wire [2:0] acks  = {m2_ack, m1_ack, m0_ack};
    wire [2:0] comps = {m2_complete, m1_complete, m0_complete};
    wire [2:0] rvs   = {m2_rvalid, m1_rvalid, m0_rvalid};

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m1_req = 0; m2_req = 0;
        m0_address = '0; m1_address = '0; m2_address = '0;
        m0_write = 0; m1_write = 0; m2_write = 0;
        m0_burst = 0; m1_burst = 0; m2_burst = 0;
        m0_wstrb = '0; m1_wstrb = '0; m2_wstrb = '0;
        m0_wdata = '0; m1_wdata = '0; m2_wdata = '0;
        sdram_ready = 0; sdram_rdata = '0; sdram_raddress = '0;
        sdram_rvalid = '0; sdram_complete = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick();
        #1;
        total++; if (sdram_request !== 3'b000) begin bad++; $display("FAIL reset_request got=%b exp=000", sdram_request); end
        total++; if (acks !== 3'b000) begin bad++; $display("FAIL reset_acks got=%b exp=000", acks); end
        total++; if (sdram_address !== 26'h0 || sdram_wdata !== 32'h0 || sdram_wstrb !== 4'h0 ||
                     sdram_write !== 1'b0 || sdram_burst !== 1'b0) begin
            bad++; $display("FAIL reset_payload got addr=%h wdata=%h wstrb=%h w=%b b=%b exp=all zero",
                            sdram_address, sdram_wdata, sdram_wstrb, sdram_write, sdram_burst);
        end
        m0_req = 1; sdram_ready = 1; sdram_complete = 1;
        #1;
        total++; if (acks !== 3'b000) begin bad++; $display("FAIL reset_held_acks got=%b exp=000", acks); end
        total++; if (comps !== 3'b000) begin bad++; $display("FAIL reset_empty_complete got=%b exp=000", comps); end
        tick();
        #1;
        total++; if (sdram_request !== 3'b000) begin bad++; $display("FAIL reset_held_request got=%b exp=000", sdram_request); end
        reset = 0;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_req [6];
        exp_req = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        do_reset();
        m0_req = 1; m0_address = 26'h0000100;
        m1_req = 1; m1_address = 26'h0000200;
        m2_req = 1; m2_address = 26'h0000300;
        sdram_ready = 1;
        #1;
        total++; if (sdram_request !== 3'b000) begin bad++; $display("FAIL rr_cycle0 got=%b exp=000", sdram_request); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i > 0) begin
                if (exp_req[i-1][0]) m0_req = 0;
                if (exp_req[i-1][1]) m1_req = 0;
                if (exp_req[i-1][2]) m2_req = 0;
            end
            #1;
            total++; if (sdram_request !== exp_req[i]) begin bad++; $display("FAIL rr_request cyc=%0d got=%b exp=%b", i+1, sdram_request, exp_req[i]); end
            total++; if (acks !== exp_req[i]) begin bad++; $display("FAIL rr_ack cyc=%0d got=%b exp=%b", i+1, acks, exp_req[i]); end
            if (i == 2) begin
                total++; if (sdram_address !== 26'h0000200) begin bad++; $display("FAIL rr_m1_addr got=%h exp=0000200", sdram_address); end
            end
        end
        // Three reads queued in order m0, m1, m2; one extra completion finds it empty.
        for (int i = 0; i < 4; i++) begin
            tick();
            sdram_complete = 1;
            #1;
            total++; if (comps !== ((i < 3) ? (3'b001 << i) : 3'b000)) begin
                bad++; $display("FAIL rr_complete k=%0d got=%b exp=%b", i, comps, (i < 3) ? (3'b001 << i) : 3'b000);
            end
        end
        sdram_complete = 0;
    endtask

    task automatic test_hold();
        do_reset();
        m1_req = 1; m1_address = 26'h0001000; m1_wdata = 32'h1234_5678;
        sdram_ready = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 2) begin
                m1_address = 26'h3FFFFFF;
                m1_wdata   = 32'hFFFF_FFFF;
            end
            #1;
            total++; if (sdram_request !== 3'b010) begin bad++; $display("FAIL hold_request c=%0d got=%b exp=010", c, sdram_request); end
            total++; if (sdram_address !== 26'h0001000 || sdram_wdata !== 32'h1234_5678) begin
                bad++; $display("FAIL hold_payload c=%0d got=%h/%h exp=0001000/12345678", c, sdram_address, sdram_wdata);
            end
            total++; if (acks !== 3'b000) begin bad++; $display("FAIL hold_noack c=%0d got=%b exp=000", c, acks); end
        end
        tick();
        sdram_ready = 1;
        #1;
        total++; if (acks !== 3'b010) begin bad++; $display("FAIL hold_ack got=%b exp=010", acks); end
        tick();
        m1_req = 0;
        #1;
        total++; if (sdram_request !== 3'b000 || acks !== 3'b000) begin
            bad++; $display("FAIL hold_after got req=%b ack=%b exp=000/000", sdram_request, acks);
        end
    endtask

    task automatic test_burst();
        do_reset();
        m2_req = 1; m2_burst = 1; m2_address = 26'h0040000;
        sdram_ready = 1;
        tick();
        #1;
        total++; if (sdram_request !== 3'b100 || acks !== 3'b100 || sdram_burst !== 1'b1) begin
            bad++; $display("FAIL burst_grant got req=%b ack=%b burst=%b exp=100/100/1", sdram_request, acks, sdram_burst);
        end
        tick();
        m2_req = 0; m2_burst = 0;
        for (int b = 0; b < 16; b++) begin
            tick();
            sdram_rvalid   = 3'b100;
            sdram_rdata    = 32'hA000_0000 + 32'(b);
            sdram_raddress = 26'h0040000 + 26'(b * 4);
            #1;
            total++; if (rvs !== 3'b100) begin bad++; $display("FAIL burst_rvalid beat=%0d got=%b exp=100", b, rvs); end
            total++; if (m_rdata !== 32'hA000_0000 + 32'(b) || m_raddress !== 26'h0040000 + 26'(b * 4)) begin
                bad++; $display("FAIL burst_data beat=%0d got=%h/%h", b, m_rdata, m_raddress);
            end
            total++; if (comps !== 3'b000) begin bad++; $display("FAIL burst_early_complete beat=%0d got=%b exp=000", b, comps); end
        end
        tick();
        sdram_rvalid = 3'b000; sdram_complete = 1;
        #1;
        total++; if (comps !== 3'b100) begin bad++; $display("FAIL burst_complete got=%b exp=100", comps); end
        tick();
        sdram_complete = 0;
        #1;
        total++; if (comps !== 3'b000 || rvs !== 3'b000) begin
            bad++; $display("FAIL burst_quiet got comp=%b rv=%b exp=000/000", comps, rvs);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        sdram_ready = 1;
        for (int k = 0; k < 4; k++) begin
            m2_req = 1; m2_address = 26'(k);
            tick();
            #1;
            total++; if (acks !== 3'b100) begin bad++; $display("FAIL full_fill k=%0d got=%b exp=100", k, acks); end
            tick();
        end
        m2_req = 0;
        m0_req = 1;
        m1_req = 1; m1_write = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
        #1;
        total++; if (sdram_request !== 3'b000) begin bad++; $display("FAIL full_idle got=%b exp=000", sdram_request); end
        tick();
        #1;
        total++; if (sdram_request !== 3'b010 || acks !== 3'b010 || sdram_write !== 1'b1 || sdram_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL full_write_wins got req=%b ack=%b w=%b d=%h exp=010/010/1/deadbeef",
                            sdram_request, acks, sdram_write, sdram_wdata);
        end
        tick();
        m1_req = 0; m1_write = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            total++; if (sdram_request !== 3'b000) begin bad++; $display("FAIL full_blocked c=%0d got=%b exp=000", c, sdram_request); end
        end
        tick();
        sdram_complete = 1;
        #1;
        total++; if (comps !== 3'b100) begin bad++; $display("FAIL full_pop got=%b exp=100", comps); end
        tick();
        sdram_complete = 0;
        #1;
        total++; if (sdram_request !== 3'b000) begin bad++; $display("FAIL full_pop_lag got=%b exp=000", sdram_request); end
        tick();
        #1;
        total++; if (sdram_request !== 3'b001 || acks !== 3'b001) begin
            bad++; $display("FAIL full_unblock got req=%b ack=%b exp=001/001", sdram_request, acks);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        sdram_ready = 1;
        m0_req = 1;
        tick();
        #1;
        total++; if (acks !== 3'b001) begin bad++; $display("FAIL pp_first got=%b exp=001", acks); end
        tick();
        m0_req = 0; m1_req = 1;
        #1;
        tick();
        sdram_complete = 1;
        #1;
        total++; if (acks !== 3'b010 || comps !== 3'b001) begin
            bad++; $display("FAIL pp_same_cycle got ack=%b comp=%b exp=010/001", acks, comps);
        end
        tick();
        m1_req = 0;
        #1;
        total++; if (comps !== 3'b010) begin bad++; $display("FAIL pp_second got=%b exp=010", comps); end
        tick();
        #1;
        total++; if (comps !== 3'b000) begin bad++; $display("FAIL pp_drained got=%b exp=000", comps); end
        m2_req = 1; sdram_complete = 0;
        tick();
        sdram_complete = 1;
        #1;
        total++; if (acks !== 3'b100 || comps !== 3'b000) begin
            bad++; $display("FAIL pp_empty_push got ack=%b comp=%b exp=100/000", acks, comps);
        end
        tick();
        m2_req = 0;
        #1;
        total++; if (comps !== 3'b100) begin bad++; $display("FAIL pp_empty_push_pop got=%b exp=100", comps); end
        tick();
        sdram_complete = 0;
    endtask

    task automatic test_reset_in_grant();
        do_reset();
        sdram_ready = 1;
        m0_req = 1;
        tick();
        #1;
        total++; if (acks !== 3'b001) begin bad++; $display("FAIL rg_first got=%b exp=001", acks); end
        tick();
        sdram_ready = 0;
        #1;
        tick();
        #1;
        total++; if (sdram_request !== 3'b001 || acks !== 3'b000) begin
            bad++; $display("FAIL rg_granted got req=%b ack=%b exp=001/000", sdram_request, acks);
        end
        tick();
        reset = 1; sdram_ready = 1;
        #1;
        total++; if (acks !== 3'b000) begin bad++; $display("FAIL rg_ack_in_reset got=%b exp=000", acks); end
        tick();
        reset = 0; m1_req = 1; sdram_complete = 1;
        #1;
        total++; if (sdram_request !== 3'b000 || acks !== 3'b000) begin
            bad++; $display("FAIL rg_dropped got req=%b ack=%b exp=000/000", sdram_request, acks);
        end
        total++; if (comps !== 3'b000) begin bad++; $display("FAIL rg_fifo_empty got=%b exp=000", comps); end
        tick();
        sdram_complete = 0;
        #1;
        total++; if (sdram_request !== 3'b001 || acks !== 3'b001) begin
            bad++; $display("FAIL rg_rr_ptr got req=%b ack=%b exp=001/001", sdram_request, acks);
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_hold();
        test_burst();
        test_fifo_full();
        test_push_pop();
        test_reset_in_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
